// File: rtl/fetch_pkg.sv
// Shared definitions for the buffered fetch front end: redirect-select encodings,
// the default queue entry layout and the NOP encoding.
package fetch_pkg;

  localparam logic [1:0] RD_NONE   = 2'b00;
  localparam logic [1:0] RD_BRANCH = 2'b01;
  localparam logic [1:0] RD_STACK  = 2'b10;

  localparam int unsigned FetchXlen = 19;

  localparam logic [FetchXlen-1:0] NOP = '0;

  typedef struct packed {
    logic [FetchXlen-1:0] pc;
    logic [FetchXlen-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} entries; flush wins over push and pop.
module fetch_queue #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 38
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [Width-1:0]        data_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  output logic [Width-1:0]        data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(Depth):0]  count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AddrW+1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the slot a same-cycle push on a full queue needs.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AddrW+1)'(do_push) - (AddrW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  push_overflow_a: assert property (@(posedge clk) disable iff (!rst)
    !(push_i && !flush_i && full_o && !do_pop));

endmodule

// File: rtl/fetch_unit_buffered.sv
// Instruction-fetch front end with a prefetch queue, credit-limited requests and redirects.
// Define FETCH_PERF_EN to add saturating perf counters (fetched, dropped, stall).
module fetch_unit_buffered
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 19,
  parameter int unsigned     PC_STEP  = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  input  logic [1:0]      redirect_sel_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic [XLEN-1:0] stack_target_i,
  output logic            dec_valid_o,
  input  logic            dec_ready_i,
  output logic [XLEN-1:0] dec_instr_o,
  output logic [XLEN-1:0] dec_pc_o,
  output logic [XLEN-1:0] dec_pcplus_o
`ifdef FETCH_PERF_EN
  ,
  output logic [XLEN-1:0] perf_fetched_o,
  output logic [XLEN-1:0] perf_dropped_o,
  output logic [XLEN-1:0] perf_stall_o
`endif
);

  localparam int unsigned     CntW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] Step = XLEN'(PC_STEP);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] out_q, out_d;
  logic [CntW-1:0] drop_q, drop_d;

  logic            redirect, dropping, push, pop, req_valid, req_fire;
  logic [XLEN-1:0] target;
  logic [CntW:0]   in_use;
  logic [CntW-1:0] q_count;
  logic            q_full, q_empty;
  entry_t          q_head, q_in;

  assign redirect = (redirect_sel_i == RD_BRANCH) || (redirect_sel_i == RD_STACK);
  assign target   = (redirect_sel_i == RD_STACK) ? stack_target_i : branch_target_i;
  assign dropping = (drop_q != '0);

  assign dec_valid_o = rst && !q_empty;
  assign pop         = dec_valid_o && dec_ready_i;
  assign push        = imem_rsp_valid_i && !dropping && !redirect;

  // The slot freed by this cycle's pop is credited immediately to sustain one fetch per cycle.
  assign in_use    = (CntW+1)'(out_q) + (CntW+1)'(q_count) - (CntW+1)'(pop);
  assign req_valid = rst && !redirect && (in_use < (CntW+1)'(DEPTH));
  assign req_fire  = req_valid && imem_req_ready_i;

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = rst ? fetch_pc_q : '0;

  assign q_in.pc    = rsp_pc_q;
  assign q_in.instr = imem_rsp_data_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    out_d      = out_q + CntW'(req_fire) - CntW'(imem_rsp_valid_i);
    if (redirect) begin
      fetch_pc_d = target;
      rsp_pc_d   = target;
      drop_d     = out_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + Step;
      if (push)     rsp_pc_d   = rsp_pc_q + Step;
      if (imem_rsp_valid_i && dropping) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  fetch_queue #(
    .Depth (DEPTH),
    .Width (2 * XLEN)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (q_in),
    .pop_i   (pop),
    .flush_i (redirect),
    .data_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  assign dec_instr_o  = dec_valid_o ? q_head.instr : XLEN'(NOP);
  assign dec_pc_o     = dec_valid_o ? q_head.pc : '0;
  assign dec_pcplus_o = dec_valid_o ? (q_head.pc + Step) : '0;

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] perf_fetched_q, perf_dropped_q, perf_stall_q;
  logic            fetched_ev, dropped_ev, stall_ev;

  assign fetched_ev = push;
  assign dropped_ev = imem_rsp_valid_i && (dropping || redirect);
  assign stall_ev   = dec_valid_o && !dec_ready_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (fetched_ev && (perf_fetched_q != '1)) perf_fetched_q <= perf_fetched_q + 1'b1;
      if (dropped_ev && (perf_dropped_q != '1)) perf_dropped_q <= perf_dropped_q + 1'b1;
      if (stall_ev && (perf_stall_q != '1))     perf_stall_q   <= perf_stall_q + 1'b1;
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_dropped_o = perf_dropped_q;
  assign perf_stall_o   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit_buffered.sv
// Scoreboard bench: accepted requests queue their expected decode output; a memory
// model with adjustable latency answers in order.
module tb_fetch_unit_buffered;
  import fetch_pkg::*;

  localparam int unsigned     XLEN     = 19;
  localparam int unsigned     DEPTH    = 2;
  localparam int unsigned     STEP     = 4;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  localparam logic [XLEN-1:0] KEY      = 19'h5A5A5;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic [1:0]      redirect_sel;
  logic [XLEN-1:0] branch_target, stack_target;
  logic            dec_valid, dec_ready;
  logic [XLEN-1:0] dec_instr, dec_pc, dec_pcplus;

  always #5 clk = ~clk;

  fetch_unit_buffered #(
    .XLEN     (XLEN),
    .PC_STEP  (STEP),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid_o (req_valid),
    .imem_req_ready_i (req_ready),
    .imem_req_addr_o  (req_addr),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .redirect_sel_i   (redirect_sel),
    .branch_target_i  (branch_target),
    .stack_target_i   (stack_target),
    .dec_valid_o      (dec_valid),
    .dec_ready_i      (dec_ready),
    .dec_instr_o      (dec_instr),
    .dec_pc_o         (dec_pc),
    .dec_pcplus_o     (dec_pcplus)
  );

  typedef struct {
    logic [XLEN-1:0] addr;
    int              due;
  } mem_ent_t;

  int              total = 0;
  int              bad = 0;
  int              cyc = 0;
  int              pops = 0;
  int              mem_lat = 1;
  int              first_req_cyc = -1;
  int              first_dec_cyc = -1;
  logic            prev_redir = 1'b0;
  logic [XLEN-1:0] exp_fetch = RESET_PC;
  logic [2*XLEN-1:0] sb[$];
  mem_ent_t        memq[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: called just after a negedge with this cycle's inputs already set.
  task automatic step();
    logic            fire, redir;
    logic [XLEN-1:0] tgt, pc_e, instr_e, pcplus_e;
    if (rst && memq.size() > 0 && memq[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = memq[0].addr ^ KEY;
      void'(memq.pop_front());
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
    end
    #1;
    if (!rst) begin
      check_eq("rst_req", {req_valid, req_addr}, '0);
      check_eq("rst_dec", {dec_valid, dec_instr, dec_pc, dec_pcplus}, '0);
      sb.delete();
      memq.delete();
      exp_fetch     = RESET_PC;
      prev_redir    = 1'b0;
      first_req_cyc = -1;
      first_dec_cyc = -1;
    end else begin
      redir = (redirect_sel == RD_BRANCH) || (redirect_sel == RD_STACK);
      tgt   = (redirect_sel == RD_STACK) ? stack_target : branch_target;
      if (prev_redir) check_eq("valid_after_redirect", dec_valid, 0);
      check_eq("credit", sb.size() <= DEPTH, 1);
      if (dec_valid) begin
        check_eq("sb_has_entry", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          {pc_e, instr_e} = sb[0];
          pcplus_e = pc_e + XLEN'(STEP);
          check_eq("dec_pc", dec_pc, pc_e);
          check_eq("dec_instr", dec_instr, instr_e);
          check_eq("dec_pcplus", dec_pcplus, pcplus_e);
          if (dec_ready) begin
            void'(sb.pop_front());
            pops++;
          end
        end
        if (first_dec_cyc < 0) begin
          first_dec_cyc = cyc;
          check_eq("first_latency", 64'(cyc - first_req_cyc), 2);
        end
      end else begin
        check_eq("idle_outs", {dec_instr, dec_pc, dec_pcplus}, '0);
      end
      if (redir) check_eq("no_req_on_redirect", req_valid, 0);
      if (req_valid) check_eq("req_addr", req_addr, exp_fetch);
      fire = req_valid && req_ready;
      if (fire) begin
        memq.push_back('{addr: req_addr, due: cyc + mem_lat});
        if (first_req_cyc < 0) first_req_cyc = cyc;
      end
      if (redir) begin
        sb.delete();
        exp_fetch = tgt;
      end else if (fire) begin
        sb.push_back({exp_fetch, exp_fetch ^ KEY});
        exp_fetch = exp_fetch + XLEN'(STEP);
      end
      prev_redir = redir;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0]     rnd;
    logic [XLEN-1:0] rtgt;
    rst           = 1'b0;
    req_ready     = 1'b1;
    dec_ready     = 1'b1;
    redirect_sel  = RD_NONE;
    branch_target = '0;
    stack_target  = '0;
    rsp_valid     = 1'b0;
    rsp_data      = '0;
    @(negedge clk);
    repeat (2) step();

    // Streaming from reset at one instruction per cycle.
    rst  = 1'b1;
    pops = 0;
    repeat (12) step();
    check_eq("throughput", pops, 10);

    // Decode back-pressure, then release.
    dec_ready = 1'b0;
    repeat (6) step();
    dec_ready = 1'b1;
    repeat (6) step();

    // Branch redirect with two requests in flight on a slower memory.
    mem_lat = 3;
    repeat (8) step();
    redirect_sel  = RD_BRANCH;
    branch_target = 19'h00100;
    step();
    redirect_sel = RD_NONE;
    mem_lat      = 1;
    repeat (10) step();

    // Stack redirect landing on a response and a pop; select 11 is a no-op.
    redirect_sel = RD_STACK;
    stack_target = 19'h02000;
    step();
    redirect_sel = 2'b11;
    repeat (2) step();
    redirect_sel = RD_NONE;
    repeat (6) step();

    // PC wrap through the top of the address space.
    redirect_sel  = RD_BRANCH;
    branch_target = 19'h7FFF8;
    step();
    redirect_sel = RD_NONE;
    repeat (8) step();

    // Reset mid-stream with requests outstanding.
    mem_lat = 2;
    repeat (6) step();
    rst = 1'b0;
    step();
    rst     = 1'b1;
    mem_lat = 1;
    repeat (10) step();

    // Randomised ready, latency and occasional redirects.
    for (int i = 0; i < 60; i++) begin
      dec_ready = ($urandom_range(0, 3) != 0);
      req_ready = ($urandom_range(0, 3) != 0);
      mem_lat   = $urandom_range(1, 3);
      rnd       = $urandom;
      rtgt      = rnd[XLEN-1:0] & ~XLEN'(3);
      if ($urandom_range(0, 11) == 0) begin
        redirect_sel = ($urandom_range(0, 1) == 0) ? RD_BRANCH : RD_STACK;
        branch_target = rtgt;
        stack_target  = rtgt ^ 19'h10000;
      end else begin
        redirect_sel = RD_NONE;
      end
      step();
    end
    redirect_sel = RD_NONE;
    dec_ready    = 1'b1;
    req_ready    = 1'b1;
    mem_lat      = 1;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit_buffered.md
Name: fetch_unit_buffered

Overview:
Parametrised instruction-fetch front end. It replaces the fixed 19-bit, single-register fetch stage.
- Issues PC-sequential requests to an instruction memory over a valid/ready request channel and accepts in-order, variable-latency responses.
- Buffers fetched instructions in a DEPTH-entry prefetch queue and hands {instr, pc, pc+step} to decode over a valid/ready handshake.
- Handles branch-target and stack-target redirects: flushes the queue and drops stale in-flight responses.

Parameters:
XLEN, 19, width of instruction, PC and target buses
PC_STEP, 4, PC increment per fetched instruction
RESET_PC, 0, PC value loaded on reset
DEPTH, 2, prefetch queue entries and maximum outstanding requests; power of 2, at least 2

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  request PC
imem_rsp_valid  in  1  response valid; always accepted, in request order
imem_rsp_data  in  XLEN  fetched instruction
redirect_sel  in  2  00 none, 01 branch target, 10 stack target, 11 none
branch_target  in  XLEN  target for sel 01
stack_target  in  XLEN  target for sel 10
dec_valid  out  1  decode output valid
dec_ready  in  1  decode accepts
dec_instr  out  XLEN  instruction; 0 (NOP) when dec_valid=0
dec_pc  out  XLEN  PC of dec_instr; 0 when invalid
dec_pcplus  out  XLEN  dec_pc+PC_STEP, mod 2^XLEN; 0 when invalid

Behaviour:
- Reset (rst=0 at posedge):
  - fetch_pc, rsp_pc <= RESET_PC.
  - Queue empty; outstanding=0; drop_cnt=0.
  - All outputs 0 while rst=0, including imem_req_addr (combinationally forced).
- Request issue:
  - imem_req_valid = (outstanding + occupancy < DEPTH) && redirect_sel∉{01,10}.
  - imem_req_addr = fetch_pc.
  - On handshake: fetch_pc += PC_STEP (wraps mod 2^XLEN); outstanding += 1.
- Response:
  - Every imem_rsp_valid cycle decrements outstanding.
  - If drop_cnt>0: data discarded, drop_cnt -= 1.
  - Otherwise {rsp_pc, data} is pushed into the queue and rsp_pc += PC_STEP.
  - The credit rule guarantees the queue never overflows; a push while full is a design-assertion failure.
- Decode side:
  - dec_valid = queue non-empty. The head entry is registered.
  - Pop on dec_valid && dec_ready.
  - Outputs hold stable while dec_valid && !dec_ready.
- Latency:
  - With a 1-cycle memory and dec_ready=1, the first request is issued in the first cycle after rst rises and dec_valid rises 2 cycles after that request.
  - Throughput is 1 instr/cycle when DEPTH≥2.
- Redirect (sel 01/10, one cycle, priority over everything):
  - fetch_pc and rsp_pc <= target.
  - Queue cleared, including any same-cycle push or pop.
  - drop_cnt <= outstanding after this cycle's request/response accounting (a same-cycle response is dropped, not counted).
  - No request is issued in the redirect cycle.
  - dec_valid=0 in the following cycle.
- Simultaneous push and pop on a full queue is allowed and keeps occupancy constant.
- Simultaneous push and pop on an empty queue is not possible; data enters first.
- Reset mid-operation:
  - All state clears immediately.
  - Responses arriving after reset for requests issued before it are the memory's responsibility. The memory must also be reset by rst.

Optional Feature:
FETCH_PERF_EN
- Defined: adds three XLEN-wide saturating counters, readable on outputs perf_fetched, perf_dropped and perf_stall:
  - perf_fetched counts queue pushes.
  - perf_dropped counts discarded responses.
  - perf_stall counts cycles with dec_valid && !dec_ready.
  - Counters clear on reset.
- Not defined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package fetch_pkg:
  - redirect-select encodings RD_NONE=2'b00, RD_BRANCH=2'b01, RD_STACK=2'b10.
  - Typedef for a queue entry {pc, instr}.
  - NOP encoding (all zeros).
- Sub-module fetch_queue:
  - Parametrised synchronous FIFO (DEPTH, entry width) with push, pop, flush, full, empty and count.
  - Flush has priority over push and pop.

Test Plan:
1. Reset, then rst=1, 1-cycle memory returning instr=addr^19'h5A5A5, dec_ready=1 -> requests at PC 0, 4, 8…; dec_pc 0, 4, 8 on consecutive cycles; dec_pcplus = dec_pc+4.
2. Hold dec_ready=0 for 6 cycles -> at most DEPTH=2 requests outstanding plus queued; no overflow; dec_instr stable; after release, PCs continue without gaps.
3. Branch redirect: sel=01, branch_target=19'h00100 while 2 requests are in flight -> both stale responses dropped; next dec_pc=19'h00100; dec_valid=0 in the cycle after the redirect.
4. Stack redirect coinciding with an imem_rsp_valid and a pop -> that response is dropped, the queue is empty, and the next dec_pc equals stack_target.
5. Wrap: RESET_PC=19'h7FFFC -> second fetched PC is 0; dec_pcplus of the first instruction is 0.
6. Apply rst=0 mid-stream with 2 requests outstanding -> outputs 0 next cycle; after release, fetch restarts at RESET_PC with outstanding=0.
